// File: rtl/cmd_sequencer.sv
// Host command sequencer: decodes single-byte UART commands, collects the
// 4-byte sample-count payload and queues one-byte ACK/NAK replies.
module cmd_sequencer #(
    parameter logic [7:0]  CONNECT_BYTE     = 8'd99,
    parameter logic [7:0]  START_BYTE       = 8'd115,
    parameter logic [7:0]  RESET_BYTE       = 8'd114,
    parameter logic [7:0]  SET_SAMPLES_BYTE = 8'd116,
    parameter logic [7:0]  ACK_BYTE         = 8'd107,
    parameter logic [7:0]  NAK_BYTE         = 8'd110,
    parameter logic [31:0] SAMPLES_DEFAULT  = 32'd1024,
    parameter logic [15:0] TIMEOUT_CYCLES   = 16'd50000,
    parameter logic [7:0]  RESET_CYCLES     = 8'd16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    input  logic        corr_busy,
    output logic [7:0]  tx_data,
    output logic        tx_req,
    output logic        start,
    output logic        sw_reset,
    output logic        connected,
    output logic [31:0] samples,
    output logic        samples_upd,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE,
        GET_SAMPLES,
        REPLY,
        RESET_HOLD
    } state_t;

    state_t      state;
    logic [31:0] shadow;
    logic [1:0]  byte_idx;
    logic [15:0] timeout_cnt;
    logic [7:0]  hold_cnt;
    logic [31:0] payload_word;

    // The value the shadow register will hold once the current byte is shifted in.
    assign payload_word = {shadow[23:0], rx_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= '0;
            byte_idx    <= '0;
            timeout_cnt <= '0;
            hold_cnt    <= '0;
            tx_data     <= '0;
            tx_req      <= 1'b0;
            start       <= 1'b0;
            sw_reset    <= 1'b0;
            connected   <= 1'b0;
            samples     <= SAMPLES_DEFAULT;
            samples_upd <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            tx_req      <= 1'b0;
            start       <= 1'b0;
            samples_upd <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CONNECT_BYTE) begin
                            connected <= 1'b1;
                            tx_data   <= ACK_BYTE;
                            state     <= REPLY;
                        end else if (rx_data == START_BYTE) begin
                            if (connected && !corr_busy) begin
                                start   <= 1'b1;
                                tx_data <= ACK_BYTE;
                            end else begin
                                tx_data <= NAK_BYTE;
                            end
                            state <= REPLY;
                        end else if (rx_data == RESET_BYTE) begin
                            sw_reset <= 1'b1;
                            hold_cnt <= '0;
                            state    <= RESET_HOLD;
                        end else if (rx_data == SET_SAMPLES_BYTE) begin
                            if (connected && !corr_busy) begin
                                shadow      <= '0;
                                byte_idx    <= '0;
                                timeout_cnt <= '0;
                                state       <= GET_SAMPLES;
                            end else begin
                                tx_data <= NAK_BYTE;
                                state   <= REPLY;
                            end
                        end else begin
                            tx_data <= NAK_BYTE;
                            state   <= REPLY;
                        end
                    end
                end

                // Every byte here is payload, even if it matches a command code.
                GET_SAMPLES: begin
                    if (rx_valid) begin
                        shadow      <= payload_word;
                        byte_idx    <= byte_idx + 2'd1;
                        timeout_cnt <= '0;
                        if (byte_idx == 2'd3) begin
                            if (payload_word != 32'd0) begin
                                samples     <= payload_word;
                                samples_upd <= 1'b1;
                                tx_data     <= ACK_BYTE;
                            end else begin
                                tx_data <= NAK_BYTE;
                            end
                            state <= REPLY;
                        end
                    end else if (timeout_cnt == TIMEOUT_CYCLES - 16'd1) begin
                        tx_data <= NAK_BYTE;
                        state   <= REPLY;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end

                REPLY: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (!tx_busy) begin
                        tx_req <= 1'b1;
                        state  <= IDLE;
                    end
                end

                // The final-cycle clear of overrun deliberately wins over a late drop.
                RESET_HOLD: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (hold_cnt == RESET_CYCLES - 8'd1) begin
                        sw_reset    <= 1'b0;
                        connected   <= 1'b0;
                        samples     <= SAMPLES_DEFAULT;
                        samples_upd <= 1'b1;
                        overrun     <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_sequencer.sv
// Self-checking bench for cmd_sequencer: directed scenarios followed by random
// command traffic, compared against a command-level model of the host protocol.
module tb_cmd_sequencer;

    localparam logic [7:0] C_BYTE = 8'd99;
    localparam logic [7:0] S_BYTE = 8'd115;
    localparam logic [7:0] R_BYTE = 8'd114;
    localparam logic [7:0] T_BYTE = 8'd116;
    localparam logic [7:0] ACK    = 8'd107;
    localparam logic [7:0] NAK    = 8'd110;
    localparam int         TO     = 300;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_busy;
    logic        corr_busy;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        start;
    logic        sw_reset;
    logic        connected;
    logic [31:0] samples;
    logic        samples_upd;
    logic        overrun;

    cmd_sequencer #(.TIMEOUT_CYCLES(16'(TO))) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .corr_busy(corr_busy), .tx_data(tx_data),
        .tx_req(tx_req), .start(start), .sw_reset(sw_reset),
        .connected(connected), .samples(samples), .samples_upd(samples_upd),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_log[$];
    int start_cnt = 0;
    int upd_cnt = 0;
    int swr_cnt = 0;
    int clash_cnt = 0;
    int busy_tx_cnt = 0;

    // Output monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_req) tx_log.push_back(tx_data);
            if (tx_req && tx_busy) busy_tx_cnt++;
            if (start) start_cnt++;
            if (start && tx_req) clash_cnt++;
            if (samples_upd) upd_cnt++;
            if (sw_reset) swr_cnt++;
        end
    end

    bit          m_conn;
    logic [31:0] m_samples;
    bit          m_overrun;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        checkOutput({tag, "_tx_req"}, 32'(tx_req), 32'd0);
        checkOutput({tag, "_start"}, 32'(start), 32'd0);
        checkOutput({tag, "_sw_reset"}, 32'(sw_reset), 32'd0);
        checkOutput({tag, "_connected"}, 32'(connected), 32'd0);
        checkOutput({tag, "_samples"}, samples, 32'd1024);
        checkOutput({tag, "_samples_upd"}, 32'(samples_upd), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_samples"}, samples, m_samples);
        checkOutput({tag, "_connected"}, 32'(connected), 32'(m_conn));
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'(m_overrun));
    endtask

    // One complete host command: model prediction, drive, then compare effects.
    task automatic runCommand(input string tag, input logic [7:0] cmd, input bit cbusy,
                              input int tx_hold, input bit extra, input logic [31:0] payload);
        int         exp_tx;
        logic [7:0] exp_byte;
        int         exp_start;
        int         exp_upd;
        int         exp_swr;
        int         s0;
        int         u0;
        int         w0;
        bit         take_payload;

        tx_log.delete();
        s0 = start_cnt;
        u0 = upd_cnt;
        w0 = swr_cnt;
        exp_tx = 1;
        exp_byte = NAK;
        exp_start = 0;
        exp_upd = 0;
        exp_swr = 0;
        take_payload = 1'b0;

        if (cmd == C_BYTE) begin
            m_conn = 1'b1;
            exp_byte = ACK;
        end else if (cmd == S_BYTE) begin
            if (m_conn && !cbusy) begin
                exp_start = 1;
                exp_byte = ACK;
            end
        end else if (cmd == R_BYTE) begin
            exp_tx = 0;
            exp_swr = 16;
            exp_upd = 1;
            m_conn = 1'b0;
            m_samples = 32'd1024;
        end else if (cmd == T_BYTE) begin
            if (m_conn && !cbusy) begin
                take_payload = 1'b1;
                if (payload != 32'd0) begin
                    m_samples = payload;
                    exp_upd = 1;
                    exp_byte = ACK;
                end
            end
        end
        if (extra) m_overrun = 1'b1;
        if (cmd == R_BYTE) m_overrun = 1'b0;

        corr_busy = cbusy;
        tx_busy = (tx_hold > 0);
        applyStimulus(cmd);
        if (take_payload) begin
            for (int i = 3; i >= 0; i--) applyStimulus(payload[8*i +: 8]);
        end
        if (extra) applyStimulus(R_BYTE);
        repeat (tx_hold) @(posedge clk);
        #1;
        tx_busy = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        corr_busy = 1'b0;

        checkOutput({tag, "_tx_count"}, 32'(tx_log.size()), 32'(exp_tx));
        if (exp_tx == 1 && tx_log.size() == 1) checkOutput({tag, "_tx_byte"}, 32'(tx_log[0]), 32'(exp_byte));
        checkOutput({tag, "_start_pulses"}, 32'(start_cnt - s0), 32'(exp_start));
        checkOutput({tag, "_upd_pulses"}, 32'(upd_cnt - u0), 32'(exp_upd));
        checkOutput({tag, "_sw_reset_cycles"}, 32'(swr_cnt - w0), 32'(exp_swr));
        checkState(tag);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [31:0] pl;
        int          pick;

        rst = 1'b1;
        rx_data = 8'd0;
        rx_valid = 1'b0;
        tx_busy = 1'b0;
        corr_busy = 1'b0;
        m_conn = 1'b0;
        m_samples = 32'd1024;
        m_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed: start before connect");
        runCommand("s_unconnected", S_BYTE, 1'b0, 0, 1'b0, 32'd0);

        $display("[TB] directed: connect and start");
        runCommand("connect", C_BYTE, 1'b0, 0, 1'b0, 32'd0);
        runCommand("start_ok", S_BYTE, 1'b0, 0, 1'b0, 32'd0);
        runCommand("start_busy", S_BYTE, 1'b1, 0, 1'b0, 32'd0);
        runCommand("other_byte", 8'h41, 1'b0, 0, 1'b0, 32'd0);

        $display("[TB] directed: sample count payloads");
        runCommand("t_1000", T_BYTE, 1'b0, 0, 1'b0, 32'h0000_1000);
        runCommand("t_zero", T_BYTE, 1'b0, 0, 1'b0, 32'h0000_0000);
        runCommand("t_busy", T_BYTE, 1'b1, 0, 1'b0, 32'h0000_0000);

        $display("[TB] directed: payload timeout");
        tx_log.delete();
        applyStimulus(T_BYTE);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        repeat (TO - 10) @(posedge clk);
        #1;
        checkOutput("timeout_early_tx", 32'(tx_log.size()), 32'd0);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("timeout_tx_count", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() == 1) checkOutput("timeout_tx_byte", 32'(tx_log[0]), 32'(NAK));
        checkState("timeout");
        runCommand("start_after_timeout", S_BYTE, 1'b0, 0, 1'b0, 32'd0);

        $display("[TB] directed: drop during reply, then software reset");
        runCommand("reply_overrun", C_BYTE, 1'b0, 5, 1'b1, 32'd0);
        runCommand("sw_reset", R_BYTE, 1'b0, 0, 1'b0, 32'd0);

        $display("[TB] directed: hard reset mid-payload");
        runCommand("reconnect", C_BYTE, 1'b0, 0, 1'b0, 32'd0);
        tx_log.delete();
        applyStimulus(T_BYTE);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        rst = 1'b1;
        #2;
        checkResetValues("rst_mid_payload");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_conn = 1'b0;
        m_samples = 32'd1024;
        m_overrun = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        checkOutput("rst_no_reply", 32'(tx_log.size()), 32'd0);
        checkState("after_rst");
        runCommand("s_after_rst", S_BYTE, 1'b0, 0, 1'b0, 32'd0);

        $display("[TB] random command traffic");
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 9);
            pl = 32'd0;
            if (pick < 2) cmd = C_BYTE;
            else if (pick < 4) cmd = S_BYTE;
            else if (pick < 5) cmd = R_BYTE;
            else if (pick < 8) begin
                cmd = T_BYTE;
                pl = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            end else begin
                do cmd = 8'($urandom);
                while (cmd == C_BYTE || cmd == S_BYTE || cmd == R_BYTE || cmd == T_BYTE);
            end
            runCommand($sformatf("rand%0d", n), cmd, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 5), 1'($urandom_range(0, 1)), pl);
        end

        checkOutput("start_tx_clash", 32'(clash_cnt), 32'd0);
        checkOutput("tx_while_busy", 32'(busy_tx_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
